breadboard_decoder: RTL and testbench
=====================================

Name: breadboard_decoder

Overview:
- Inverse of the 4-in/10-out breadboard function block.
- Training phase: sweeps every 4-bit input w,x,y,z (0..15) into an external breadboard instance and records each 10-bit response f9..f0 in a 16-entry table.
- Decode phase: accepts 10-bit codes over a valid/ready handshake, searches the table sequentially and returns the 4-bit input that produced the code, with hit and ambiguity flags.
- Sits beside the breadboard as its reader/decoder; also serves as a self-checking harness.

Parameters:
SETTLE_CYCLES, 2, cycles drive_wxyz is held before resp_f is sampled (1..15).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- train_start  in  1  pulse; begins training; sampled only in IDLE or READY
- drive_wxyz  out  4  stimulus to breadboard; bit3=w, bit2=x, bit1=y, bit0=z
- resp_f  in  10  breadboard response; bit0=f0 .. bit9=f9
- train_done  out  1  table valid
- in_valid  in  1  code presented
- in_ready  out  1  decoder can accept a code
- in_code  in  10  code to decode
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_nibble  out  4  decoded w,x,y,z (lowest matching index)
- out_hit  out  1  at least one table entry matched
- out_multi  out  1  two or more entries matched

Behaviour:
- Reset (synchronous, active high, overrides everything):
  - state=IDLE; drive_wxyz=0, train_done=0, in_ready=0, out_valid=0, out_nibble=0, out_hit=0, out_multi=0.
  - Table contents are not reset; they are gated by train_done.
  - Reset mid-training or mid-search abandons the operation; retraining is required.
- States: IDLE, TRAIN, READY, SEARCH, RESPOND.
- IDLE: in_ready=0. train_start=1 -> TRAIN with idx=0, settle counter=0, drive_wxyz=0.
- TRAIN:
  - drive_wxyz=idx; the counter increments each cycle.
  - When counter==SETTLE_CYCLES, table[idx]<=resp_f and the counter clears.
  - If idx<15: idx++ and drive_wxyz updates on the same edge.
  - If idx==15: drive_wxyz<=0, train_done<=1, go to READY.
  - Each entry takes SETTLE_CYCLES+1 cycles. train_start accepted at edge k gives train_done high after edge k+16*(SETTLE_CYCLES+1); 48 cycles at default.
  - train_done=0 throughout TRAIN, including retraining.
  - train_start and in_valid are ignored during TRAIN.
- READY:
  - in_ready=1.
  - If train_start=1, retrain (-> TRAIN, train_done<=0). This takes priority over a simultaneous in_valid; that code is not accepted.
  - Otherwise in_valid&in_ready latches in_code and goes to SEARCH with idx=0 and the hit/multi accumulators cleared.
- SEARCH:
  - in_ready=0. Each cycle compare table[idx] against the latched code.
  - On the first match, record idx and set hit. On any later match, set multi.
  - Exactly 16 cycles, with no early exit. A code accepted at edge k gives out_valid high after edge k+16.
- RESPOND:
  - out_valid=1. out_nibble, out_hit and out_multi are held stable until out_valid&out_ready.
  - On a miss: out_nibble=0, out_hit=0, out_multi=0.
  - On handshake, out_valid<=0 and go to READY. in_ready rises the cycle after the handshake; there is no same-cycle accept.
  - train_start is ignored in SEARCH and RESPOND.
- All comparisons are full 10-bit equality. The index is 4 bits, and the sweep terminates at idx==15 with no wrap.

Decomposition:
- Package breadboard_pkg: CODE_W=10, NIB_W=4, NUM_ENTRIES=16, state enum (IDLE, TRAIN, READY, SEARCH, RESPOND).
- Sub-module breadboard_code_table: 16x10 register array with one synchronous write port (we, waddr, wdata) and a combinational read (raddr -> rdata).
- The FSM, counters and handshake stay in breadboard_decoder.

Test Plan:
1. Reset, then train_start pulse with bench model resp_f=(drive_wxyz*37+5) mod 1024 and SETTLE_CYCLES=2 -> drive_wxyz steps 0..15, each value held 3 cycles; train_done rises exactly 48 cycles after the start edge; drive_wxyz returns to 0.
2. After scenario 1, send in_code=116 -> out_valid 16 cycles after accept; out_nibble=3, out_hit=1, out_multi=0. Then in_code=0 -> out_hit=0, out_nibble=0.
3. Model resp_f=drive_wxyz&4'b1110, send in_code=6 -> out_nibble=6, out_hit=1, out_multi=1.
4. out_ready held low 10 cycles in RESPOND -> outputs stable and in_ready=0 throughout; in_ready=1 the cycle after the handshake.
5. Assert rst during SEARCH -> all outputs 0 and train_done=0 next cycle; in_valid is ignored until retraining completes. In READY, assert train_start and in_valid together -> retrain, code not accepted.
6. Connect a real breadboard instance and train -> for each idx 0..15, querying its recorded code returns the lowest index with an identical code, with out_multi=1 exactly where codes collide.

Source files
------------

// File: rtl/breadboard_pkg.sv
//==============================================================================
// Module : breadboard_pkg
// Brief  : Shared widths, table depth and FSM state type for the breadboard
//          decoder slice.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package breadboard_pkg;

    localparam int CODE_W      = 10;
    localparam int NIB_W       = 4;
    localparam int NUM_ENTRIES = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRAIN   = 3'd1,
        READY   = 3'd2,
        SEARCH  = 3'd3,
        RESPOND = 3'd4
    } state_t;

endpackage : breadboard_pkg

`default_nettype wire

// File: rtl/breadboard_code_table.sv
//==============================================================================
// Module : breadboard_code_table
// Brief  : 16 x 10-bit response table, one synchronous write port and one
//          combinational read port. Contents are intentionally not reset.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module breadboard_code_table
    import breadboard_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [NIB_W-1:0]  waddr,
    input  logic [CODE_W-1:0] wdata,
    input  logic [NIB_W-1:0]  raddr,
    output logic [CODE_W-1:0] rdata
);

    logic [CODE_W-1:0] r_mem [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : breadboard_code_table

`default_nettype wire

// File: rtl/breadboard_decoder.sv
//==============================================================================
// Module : breadboard_decoder
// Brief  : Trains a table by sweeping all 16 breadboard inputs, then decodes
//          10-bit codes back to the lowest matching 4-bit input.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module breadboard_decoder
    import breadboard_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              train_start,
    output logic [NIB_W-1:0]  drive_wxyz,
    input  logic [CODE_W-1:0] resp_f,
    output logic              train_done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NIB_W-1:0]  out_nibble,
    output logic              out_hit,
    output logic              out_multi
);

    localparam logic [NIB_W-1:0] c_settle   = NIB_W'(SETTLE_CYCLES);
    localparam logic [NIB_W-1:0] c_last_idx = NIB_W'(NUM_ENTRIES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NIB_W-1:0]  r_idx;
    logic [NIB_W-1:0]  r_cnt;
    logic [NIB_W-1:0]  r_drive;
    logic [NIB_W-1:0]  r_nibble;
    logic              r_train_done;
    logic              r_hit;
    logic              r_multi;
    logic [CODE_W-1:0] r_code;

    logic              w_settled;
    logic              w_last;
    logic              w_we;
    logic              w_match;
    logic [CODE_W-1:0] w_rdata;

    assign w_settled = (r_cnt == c_settle);
    assign w_last    = (r_idx == c_last_idx);
    assign w_we      = (r_state == TRAIN) && w_settled;
    assign w_match   = (w_rdata == r_code);

    // Write and search share r_idx as the table address.
    breadboard_code_table u_table (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_idx),
        .wdata (resp_f),
        .raddr (r_idx),
        .rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (train_start)             w_state_nxt = TRAIN;
            TRAIN:   if (w_settled && w_last)     w_state_nxt = READY;
            READY: begin
                if (train_start)                  w_state_nxt = TRAIN;
                else if (in_valid)                w_state_nxt = SEARCH;
            end
            SEARCH:  if (w_last)                  w_state_nxt = RESPOND;
            RESPOND: if (out_ready)               w_state_nxt = READY;
            default:                              w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_drive      <= '0;
            r_nibble     <= '0;
            r_train_done <= 1'b0;
            r_hit        <= 1'b0;
            r_multi      <= 1'b0;
            r_code       <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (train_start) begin
                        r_idx        <= '0;
                        r_cnt        <= '0;
                        r_drive      <= '0;
                        r_train_done <= 1'b0;
                    end
                end
                TRAIN: begin
                    if (w_settled) begin
                        r_cnt <= '0;
                        if (w_last) begin
                            r_drive      <= '0;
                            r_train_done <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_drive <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                READY: begin
                    // Retrain wins over a simultaneous code offer.
                    if (train_start) begin
                        r_idx        <= '0;
                        r_cnt        <= '0;
                        r_drive      <= '0;
                        r_train_done <= 1'b0;
                    end else if (in_valid) begin
                        r_code   <= in_code;
                        r_idx    <= '0;
                        r_hit    <= 1'b0;
                        r_multi  <= 1'b0;
                        r_nibble <= '0;
                    end
                end
                SEARCH: begin
                    if (w_match) begin
                        if (!r_hit) begin
                            r_hit    <= 1'b1;
                            r_nibble <= r_idx;
                        end else begin
                            r_multi  <= 1'b1;
                        end
                    end
                    if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign drive_wxyz = r_drive;
    assign train_done = r_train_done;
    assign in_ready   = (r_state == READY);
    assign out_valid  = (r_state == RESPOND);
    assign out_nibble = r_nibble;
    assign out_hit    = r_hit;
    assign out_multi  = r_multi;

endmodule : breadboard_decoder

`default_nettype wire

// File: tb/tb_breadboard_decoder.sv
//==============================================================================
// Module : tb_breadboard_decoder
// Brief  : Directed + randomized checks of breadboard_decoder against a
//          table-search reference model and a modelled breadboard.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_breadboard_decoder;

    localparam int S         = 2;
    localparam int TRAIN_CYC = 16 * (S + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       train_start;
    logic [3:0] drive_wxyz;
    logic [9:0] resp_f;
    logic       train_done;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_nibble;
    logic       out_hit;
    logic       out_multi;

    int         vectors     = 0;
    int         miscompares = 0;
    int         mode        = 0;
    logic [9:0] bb_tab  [16];
    logic [9:0] ref_tab [16];

    always #5 clk = ~clk;

    // Modelled breadboard: 0 = affine code, 1 = masked nibble, 2 = random table
    assign resp_f = (mode == 0) ? 10'((int'(drive_wxyz) * 37 + 5) % 1024) :
                    (mode == 1) ? {6'd0, drive_wxyz & 4'b1110} :
                                  bb_tab[drive_wxyz];

    breadboard_decoder #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .train_start (train_start),
        .drive_wxyz  (drive_wxyz),
        .resp_f      (resp_f),
        .train_done  (train_done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_code     (in_code),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_nibble  (out_nibble),
        .out_hit     (out_hit),
        .out_multi   (out_multi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_model(input int m);
        mode = m;
        for (int i = 0; i < 16; i++) begin
            case (m)
                0:       ref_tab[i] = 10'((i * 37 + 5) % 1024);
                1:       ref_tab[i] = 10'(i & 14);
                default: ref_tab[i] = bb_tab[i];
            endcase
        end
    endtask

    function automatic void ref_decode(input logic [9:0] code, output logic [3:0] nib,
                                       output logic hit, output logic multi);
        int n = 0;
        nib = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (ref_tab[i] == code) begin
                if (n == 0) nib = i[3:0];
                n++;
            end
        end
        hit   = (n > 0);
        multi = (n > 1);
    endfunction

    // Called at a negedge with the DUT in IDLE or READY.
    task automatic do_train(input logic with_valid);
        train_start = 1'b1;
        in_valid    = with_valid;
        in_code     = 10'd116;
        @(negedge clk);
        train_start = 1'b0;
        in_valid    = 1'b0;
        for (int i = 0; i < TRAIN_CYC; i++) begin
            chk("train_drive", drive_wxyz, i / (S + 1));
            chk("train_done_low", train_done, 0);
            if (with_valid) begin
                chk("train_in_ready", in_ready, 0);
                chk("train_out_valid", out_valid, 0);
            end
            @(negedge clk);
        end
        chk("train_done_high", train_done, 1);
        chk("train_drive_end", drive_wxyz, 0);
        chk("train_ready", in_ready, 1);
    endtask

    task automatic do_query(input logic [9:0] code, input int hold);
        logic [3:0] en;
        logic       eh, em;
        int         c;
        ref_decode(code, en, eh, em);
        chk("q_in_ready_pre", in_ready, 1);
        in_valid = 1'b1;
        in_code  = code;
        @(negedge clk);
        in_valid = 1'b0;
        in_code  = 10'($urandom);
        chk("q_in_ready_busy", in_ready, 0);
        c = 0;
        while (out_valid !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("q_latency", c, 16);
        chk("q_nibble", out_nibble, en);
        chk("q_hit", out_hit, eh);
        chk("q_multi", out_multi, em);
        chk("q_in_ready_resp", in_ready, 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("q_hold_valid", out_valid, 1);
            chk("q_hold_nibble", out_nibble, en);
            chk("q_hold_hit", out_hit, eh);
            chk("q_hold_multi", out_multi, em);
            chk("q_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("q_post_valid", out_valid, 0);
        chk("q_post_in_ready", in_ready, 1);
    endtask

    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; train_start = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0;
        set_model(0);
        repeat (3) @(negedge clk);
        chk("rst_drive", drive_wxyz, 0);
        chk("rst_train_done", train_done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_nibble", out_nibble, 0);
        chk("rst_hit", out_hit, 0);
        chk("rst_multi", out_multi, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);

        // Affine breadboard: known hit and miss, then random codes
        do_train(1'b0);
        do_query(10'd116, 0);
        chk("fix_116", out_nibble === 4'd3 || !out_hit, 1);
        do_query(10'd0, 1);
        for (int n = 0; n < 8; n++) begin
            logic [9:0] code;
            code = ($urandom_range(0, 1) == 1) ? ref_tab[$urandom_range(0, 15)] : 10'($urandom);
            do_query(code, $urandom_range(0, 3));
        end

        // Colliding breadboard; long backpressure
        set_model(1);
        do_train(1'b0);
        do_query(10'd6, 10);
        do_query(10'd14, 2);
        do_query(10'd1, 0);

        // Reset mid-search, then in_valid ignored until retrained
        set_model(0);
        in_valid = 1'b1;
        in_code  = 10'd116;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_train_done", train_done, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_nibble", out_nibble, 0);
        chk("mid_rst_hit", out_hit, 0);
        chk("mid_rst_multi", out_multi, 0);
        chk("mid_rst_drive", drive_wxyz, 0);
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_in_ready", in_ready, 0);
            chk("post_rst_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        do_train(1'b0);
        do_train(1'b1);
        do_query(10'd116, 0);

        // Random breadboard with deliberate collisions; query every entry
        for (int i = 0; i < 16; i++) bb_tab[i] = 10'($urandom_range(0, 5) * 131 + 7);
        set_model(2);
        do_train(1'b0);
        for (int i = 0; i < 16; i++) begin
            do_query(bb_tab[i], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_breadboard_decoder

`default_nettype wire
